// File: rtl/skinny_sbox8_dom1_seq_ctrl.sv
// Byte-serial controller that feeds a shared (first-order DOM) state, one byte at a
// time, through an external 4-cycle SKINNY-8 sbox and collects the result shares.
module skinny_sbox8_dom1_seq_ctrl #(
  parameter int NBYTES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   st0_i,
  input  logic [8*NBYTES-1:0]   st1_i,
  output logic [8*NBYTES-1:0]   st0_o,
  output logic [8*NBYTES-1:0]   st1_o,
  input  logic [15:0]           rnd_i,
  input  logic                  rnd_valid_i,
  output logic                  rnd_ready_o,
  output logic [7:0]            sb_si0,
  output logic [7:0]            sb_si1,
  output logic [15:0]           sb_r,
  input  logic [7:0]            sb_bo0,
  input  logic [7:0]            sb_bo1,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EVAL  = 3'd2,
    CAPT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

  state_t              state;
  state_t              state_nxt;
  logic [3:0]          idx;
  logic [1:0]          cnt;
  logic [8*NBYTES-1:0] w0;
  logic [8*NBYTES-1:0] w1;
  logic [7:0]          h0;
  logic [7:0]          h1;
  logic [15:0]         hr;
  logic [7:0]          w0_sel;
  logic [7:0]          w1_sel;
  logic                last_byte;
  logic                rnd_fire;

  assign last_byte = (idx == LAST_IDX);

  // Mask handshake: a word transfers on a rising edge where rnd_valid_i and
  // rnd_ready_o are both 1; ready depends only on state and never on valid,
  // and each transferred word is consumed by exactly one byte.
  assign rnd_fire  = rnd_ready_o & rnd_valid_i;

  // Sbox inputs come straight from the hold registers so they stay frozen
  // for the whole evaluation window of a byte.
  assign sb_si0    = h0;
  assign sb_si1    = h1;
  assign sb_r      = hr;
  assign dbg_state = state;

  always_comb begin
    w0_sel = '0;
    w1_sel = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (idx == 4'(k)) begin
        w0_sel = w0[8*k +: 8];
        w1_sel = w1[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rnd_ready_o = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        busy        = 1'b1;
        rnd_ready_o = 1'b1;
        if (rnd_valid_i) begin
          state_nxt = EVAL;
        end
      end
      EVAL: begin
        busy = 1'b1;
        if (cnt == 2'd3) begin
          state_nxt = CAPT;
        end
      end
      CAPT: begin
        busy      = 1'b1;
        state_nxt = last_byte ? DONE : FETCH;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Control outputs read as inactive while reset is held, even before the edge.
    if (rst) begin
      rnd_ready_o = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      cnt   <= '0;
      w0    <= '0;
      w1    <= '0;
      h0    <= '0;
      h1    <= '0;
      hr    <= '0;
      st0_o <= '0;
      st1_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            w0  <= st0_i;
            w1  <= st1_i;
            idx <= '0;
          end
        end
        FETCH: begin
          if (rnd_fire) begin
            h0  <= w0_sel;
            h1  <= w1_sel;
            hr  <= rnd_i;
            cnt <= '0;
          end
        end
        EVAL: begin
          if (cnt != 2'd3) begin
            cnt <= cnt + 2'd1;
          end
        end
        CAPT: begin
          // Each output share lands in its own working register; shares never meet.
          for (int k = 0; k < NBYTES; k++) begin
            if (idx == 4'(k)) begin
              w0[8*k +: 8] <= sb_bo0;
              w1[8*k +: 8] <= sb_bo1;
            end
          end
          if (!last_byte) begin
            idx <= idx + 4'd1;
          end
        end
        DONE: begin
          st0_o <= w0;
          st1_o <= w1;
          h0    <= '0;
          h1    <= '0;
          hr    <= '0;
        end
        default: begin
          idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_skinny_sbox8_dom1_seq_ctrl.sv
// Bench for the byte-serial shared sbox controller: drives full 16-byte runs and a
// 1-byte build against a latency-accurate external sbox model and a reference S-box.
module tb_skinny_sbox8_dom1_seq_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] st0_i = '0;
  logic [127:0] st1_i = '0;
  logic [127:0] st0_o;
  logic [127:0] st1_o;
  logic [15:0]  rnd_i = '0;
  logic         rnd_valid_i = 1'b1;
  logic         rnd_ready_o;
  logic [7:0]   sb_si0;
  logic [7:0]   sb_si1;
  logic [15:0]  sb_r;
  logic [7:0]   sb_bo0;
  logic [7:0]   sb_bo1;
  logic         busy;
  logic         done;
  logic [2:0]   dbg_state;

  logic         start1 = 1'b0;
  logic [7:0]   st0_i1 = '0;
  logic [7:0]   st1_i1 = '0;
  logic [7:0]   st0_o1;
  logic [7:0]   st1_o1;
  logic [15:0]  rnd_i1 = '0;
  logic         rnd_valid_i1 = 1'b1;
  logic         rnd_ready_o1;
  logic [7:0]   sb_si0_1;
  logic [7:0]   sb_si1_1;
  logic [15:0]  sb_r1;
  logic [7:0]   sb_bo0_1;
  logic [7:0]   sb_bo1_1;
  logic         busy1;
  logic         done1;
  logic [2:0]   dbg_state1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  skinny_sbox8_dom1_seq_ctrl #(.NBYTES(16)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .st0_i(st0_i), .st1_i(st1_i), .st0_o(st0_o), .st1_o(st1_o),
    .rnd_i(rnd_i), .rnd_valid_i(rnd_valid_i), .rnd_ready_o(rnd_ready_o),
    .sb_si0(sb_si0), .sb_si1(sb_si1), .sb_r(sb_r),
    .sb_bo0(sb_bo0), .sb_bo1(sb_bo1),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  skinny_sbox8_dom1_seq_ctrl #(.NBYTES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .st0_i(st0_i1), .st1_i(st1_i1), .st0_o(st0_o1), .st1_o(st1_o1),
    .rnd_i(rnd_i1), .rnd_valid_i(rnd_valid_i1), .rnd_ready_o(rnd_ready_o1),
    .sb_si0(sb_si0_1), .sb_si1(sb_si1_1), .sb_r(sb_r1),
    .sb_bo0(sb_bo0_1), .sb_bo1(sb_bo1_1),
    .busy(busy1), .done(done1), .dbg_state(dbg_state1)
  );

  // SKINNY-8 S-box from its bit-sliced round definition.
  function automatic logic [7:0] sb_mix(input logic [7:0] x);
    logic [7:0] t;
    t = ((x >> 1) | x) >> 2;
    return (~t & 8'h11) ^ x;
  endfunction

  function automatic logic [7:0] sb_perm(input logic [7:0] x);
    return ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5) |
           ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
  endfunction

  function automatic logic [7:0] skinny_s(input logic [7:0] x);
    logic [7:0] y;
    y = sb_mix(x);
    y = sb_mix(sb_perm(y));
    y = sb_mix(sb_perm(y));
    y = sb_mix(sb_perm(y));
    return (y & 8'hF9) | ((y >> 1) & 8'h02) | ((y << 1) & 8'h04);
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] p, input int n);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) begin
      r[8*k +: 8] = (k < n) ? skinny_s(p[8*k +: 8]) : p[8*k +: 8];
    end
    return r;
  endfunction

  // External sbox: output at cycle t is a function of the inputs seen at cycle t-4.
  logic [31:0] sbp  [4];
  logic [31:0] sbp1 [4];
  always @(posedge clk) begin
    sbp[0]  <= {sb_si0, sb_si1, sb_r};
    sbp1[0] <= {sb_si0_1, sb_si1_1, sb_r1};
    for (int i = 1; i < 4; i++) begin
      sbp[i]  <= sbp[i-1];
      sbp1[i] <= sbp1[i-1];
    end
  end

  always_comb begin
    sb_bo1   = sbp[3][7:0] ^ sbp[3][15:8];
    sb_bo0   = skinny_s(sbp[3][31:24] ^ sbp[3][23:16]) ^ sb_bo1;
    sb_bo1_1 = sbp1[3][7:0] ^ sbp1[3][15:8];
    sb_bo0_1 = skinny_s(sbp1[3][31:24] ^ sbp1[3][23:16]) ^ sb_bo1_1;
  end

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({busy, done, rnd_ready_o} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_ctrl: got busy/done/ready %b want 000", {busy, done, rnd_ready_o});
    end
    n_checks++;
    if ({st0_o, st1_o} !== 256'd0) begin
      n_errors++;
      $display("FAIL reset_state_out: got %h %h want 0", st0_o, st1_o);
    end
    n_checks++;
    if ({sb_si0, sb_si1, sb_r} !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_sb_out: got %h want 0", {sb_si0, sb_si1, sb_r});
    end
    n_checks++;
    if ({busy1, done1, rnd_ready_o1, st0_o1, st1_o1} !== 19'd0) begin
      n_errors++;
      $display("FAIL reset_nb1: got %h want 0", {busy1, done1, rnd_ready_o1, st0_o1, st1_o1});
    end
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_start_priority: got busy %b want 0", busy);
    end
  endtask

  // One full run of the 16-byte instance; stall, mid-run start and mid-run reset
  // are optional (negative cycle numbers disable them).
  task automatic run_case(input string name, input logic [127:0] s0, input logic [127:0] s1,
                          input bit zero_rnd, input int stall_byte, input int stall_n,
                          input int mid_start_at, input int rst_at, input int exp_done);
    int hs, stalled, win, win_err, busy_err, hold_err, done_cyc;
    logic [7:0] e0, e1;
    logic [15:0] er;
    logic [127:0] prev0, prev1, exp_x;
    hs = 0; stalled = 0; win = 0; win_err = 0; busy_err = 0; hold_err = 0; done_cyc = -1;
    e0 = '0; e1 = '0; er = '0;
    @(negedge clk);
    prev0 = st0_o;
    prev1 = st1_o;
    for (int c = 0; c < 400; c++) begin
      if (c == 0) begin
        st0_i = s0;
        st1_i = s1;
        start = 1'b1;
      end else begin
        st0_i = rand128();
        st1_i = rand128();
        start = (c == mid_start_at);
      end
      rst = (c == rst_at);
      #1;
      if (rst_at >= 0 && c == rst_at + 1) begin
        n_checks++;
        if ({busy, done, rnd_ready_o} !== 3'b000) begin
          n_errors++;
          $display("FAIL %s rst_ctrl: got %b want 000", name, {busy, done, rnd_ready_o});
        end
        n_checks++;
        if ({st0_o, st1_o} !== 256'd0) begin
          n_errors++;
          $display("FAIL %s rst_state_out: got %h %h want 0", name, st0_o, st1_o);
        end
        n_checks++;
        if ({sb_si0, sb_si1, sb_r} !== 32'd0) begin
          n_errors++;
          $display("FAIL %s rst_sb_out: got %h want 0", name, {sb_si0, sb_si1, sb_r});
        end
        start = 1'b0;
        return;
      end
      if (win > 0) begin
        if ({sb_si0, sb_si1, sb_r} !== {e0, e1, er}) win_err++;
        win--;
      end
      if (c >= 1 && done_cyc < 0 && !(rst_at >= 0 && c >= rst_at) && busy !== 1'b1) busy_err++;
      if (done_cyc < 0 && (st0_o !== prev0 || st1_o !== prev1)) hold_err++;
      if (done === 1'b1 && done_cyc < 0) done_cyc = c;
      if (done_cyc >= 0 && c == done_cyc + 1) break;
      rnd_i       = zero_rnd ? 16'h0000 : 16'($urandom_range(0, 65535));
      rnd_valid_i = 1'b1;
      if (rnd_ready_o && hs == stall_byte && stalled < stall_n) begin
        rnd_valid_i = 1'b0;
        stalled++;
      end
      if (rnd_ready_o && rnd_valid_i) begin
        e0  = s0[8*hs +: 8];
        e1  = s1[8*hs +: 8];
        er  = rnd_i;
        hs++;
        win = 5;
      end
      @(negedge clk);
    end
    start       = 1'b0;
    rnd_valid_i = 1'b1;
    exp_x       = ref_sub(s0 ^ s1, 16);
    n_checks++;
    if (done_cyc != exp_done) begin
      n_errors++;
      $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, exp_done);
    end
    if (done_cyc < 0) return;
    n_checks++;
    if ((st0_o ^ st1_o) !== exp_x) begin
      n_errors++;
      $display("FAIL %s result: got %h want %h", name, st0_o ^ st1_o, exp_x);
    end
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_errors++;
      $display("FAIL %s after_done: got done/busy %b want 00", name, {done, busy});
    end
    n_checks++;
    if (hs != 16) begin
      n_errors++;
      $display("FAIL %s rnd_handshakes: got %0d want 16", name, hs);
    end
    n_checks++;
    if (win_err != 0) begin
      n_errors++;
      $display("FAIL %s sb_window: got %0d bad cycles want 0", name, win_err);
    end
    n_checks++;
    if (busy_err != 0) begin
      n_errors++;
      $display("FAIL %s busy_during_run: got %0d low cycles want 0", name, busy_err);
    end
    n_checks++;
    if (hold_err != 0) begin
      n_errors++;
      $display("FAIL %s out_hold: got %0d changed cycles want 0", name, hold_err);
    end
  endtask

  task automatic test_zero_state();
    run_case("zero_state", 128'd0, 128'd0, 1'b1, -1, 0, -1, -1, 97);
    n_checks++;
    if ((st0_o ^ st1_o) !== {16{8'h65}}) begin
      n_errors++;
      $display("FAIL zero_const: got %h want all 65", st0_o ^ st1_o);
    end
  endtask

  task automatic test_random_masking();
    logic [127:0] p, m;
    for (int i = 0; i < 3; i++) begin
      p = rand128();
      m = rand128();
      run_case("random_masking", m ^ p, m, 1'b0, -1, 0, -1, -1, 97);
    end
  endtask

  task automatic test_rnd_stall();
    logic [127:0] p, m;
    p = rand128();
    m = rand128();
    run_case("rnd_stall", m ^ p, m, 1'b0, 5, 3, -1, -1, 100);
  endtask

  task automatic test_mid_start();
    logic [127:0] p, m;
    p = rand128();
    m = rand128();
    run_case("mid_start", m ^ p, m, 1'b0, -1, 0, 30, -1, 97);
  endtask

  task automatic test_reset_mid_run();
    logic [127:0] p, m;
    p = rand128();
    m = rand128();
    run_case("reset_mid_run", m ^ p, m, 1'b0, -1, 0, -1, 40, 97);
    p = rand128();
    m = rand128();
    run_case("after_reset", m ^ p, m, 1'b0, -1, 0, -1, -1, 97);
  endtask

  task automatic test_back_to_back();
    logic [127:0] p, m;
    for (int i = 0; i < 2; i++) begin
      p = rand128();
      m = rand128();
      run_case("back_to_back", m ^ p, m, 1'b0, (i == 0) ? 15 : 0, 2, -1, -1, 99);
    end
  endtask

  task automatic test_nbytes1();
    int hs, done_cyc;
    logic [7:0] p, m;
    hs = 0; done_cyc = -1;
    p = 8'($urandom_range(0, 255));
    m = 8'($urandom_range(0, 255));
    @(negedge clk);
    for (int c = 0; c < 40; c++) begin
      if (c == 0) begin
        st0_i1 = m ^ p;
        st1_i1 = m;
        start1 = 1'b1;
      end else begin
        st0_i1 = 8'($urandom_range(0, 255));
        st1_i1 = 8'($urandom_range(0, 255));
        start1 = 1'b0;
      end
      #1;
      if (done1 === 1'b1 && done_cyc < 0) done_cyc = c;
      if (done_cyc >= 0 && c == done_cyc + 1) break;
      rnd_i1       = 16'($urandom_range(0, 65535));
      rnd_valid_i1 = 1'b1;
      if (rnd_ready_o1) hs++;
      @(negedge clk);
    end
    start1 = 1'b0;
    n_checks++;
    if (done_cyc != 7) begin
      n_errors++;
      $display("FAIL nbytes1 done_cycle: got %0d want 7", done_cyc);
    end
    n_checks++;
    if ((st0_o1 ^ st1_o1) !== skinny_s(p)) begin
      n_errors++;
      $display("FAIL nbytes1 result: got %h want %h", st0_o1 ^ st1_o1, skinny_s(p));
    end
    n_checks++;
    if (hs != 1) begin
      n_errors++;
      $display("FAIL nbytes1 rnd_handshakes: got %0d want 1", hs);
    end
  endtask

  initial begin
    test_reset();
    test_zero_state();
    test_random_masking();
    test_rnd_stall();
    test_mid_start();
    test_reset_mid_run();
    test_back_to_back();
    test_nbytes1();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
